multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Parametrised multicycle RV32I-subset control unit: decodes full R/I/L/S/SB/JAL/JALR/CSRR formats and drives the existing datapath (register file, ULA) over multiple cycles.
- Fetches through a request/valid instruction port and stalls on the data-memory busy handshake.
- Takes interrupts at instruction boundaries, saving the return PC in sepc.

Parameters:
- NBITS, 8, datapath/PC width.
- NREGS, 32, register count; register index width is clog2(NREGS).
- WIDTH_ALUF, 4, ULA function code width; codes {funct7[5],funct3}: ADD=0000, SUB=1000, SLL=0001, SLT=0010, SLTU=0011, XOR=0100, SRL=0101, SRA=1101, OR=0110, AND=0111.
- NINSTR_BITS, 32, instruction width.
- IVEC, 8'h10, interrupt vector address, truncated to NBITS.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- instr_req  out  1  fetch request.
- instr_addr  out  NBITS  fetch address (= pc).
- instr_valid  in  1  instr is valid this cycle.
- instr  in  NINSTR_BITS  fetched instruction.
- RS1, RS2, RD  out  clog2(NREGS)  register indices.
- IMM  out  NBITS  signed immediate, sign-extended or truncated.
- ALUSrc  out  1  ULA operand B = IMM.
- ALUControl  out  WIDTH_ALUF  ULA function.
- MemtoReg  out  1  writeback from memory.
- RegWrite  out  1  register write strobe.
- link  out  1  write pclink into RD.
- pclink  out  NBITS  link value.
- Zero, Neg, Carry  in  1 each  ULA flags; Carry = carry-out of a−b.
- MemRead, MemWrite  out  1 each  data-memory strobes.
- busy  in  1  memory not ready.
- interrupt  in  1  level-sensitive interrupt request.
- illegal  out  1  illegal-opcode pulse (see optional feature).
- dbg_pc  out  NBITS  committed pc.
- dbg_state  out  2  FSM state.

Behaviour:
- Reset (synchronous, active-high): pc=0, sepc=0, in_isr=0, state=FETCH. All outputs 0 except instr_addr=0.
- FETCH:
  - instr_req=1.
  - On instr_valid: latch IR; go EXEC.
  - instr is ignored outside FETCH.
- EXEC (exactly one cycle):
  - Decode IR[6:2]; drive RS1/RS2/RD/IMM/ALUSrc/ALUControl.
  - RType: ALUControl={funct7[5],funct3}; RegWrite=1.
  - IType: ALUControl={0,funct3}, except SRAI uses {funct7[5],funct3}; ALUSrc=1; RegWrite=1.
  - LType/SType: ALUControl=ADD; ALUSrc=1; go MEM.
  - SBType: ALUControl=SUB; taken condition by funct3:
    - BEQ: Zero.
    - BNE: !Zero.
    - BLT: Neg.
    - BGE: !Neg.
    - BLTU: !Carry.
    - BGEU: Carry.
  - SBType target: pc+IMM; otherwise next = pc+4.
  - IJal: link=1, pclink=pc+4, RegWrite=1; next = pc+IMM.
  - IJalr: link=1, pclink=pc+4, RegWrite=1; next = PC-from-ULA result is not used — next = (RS1 value via ULA ADD IMM); the ULA result is taken from the datapath; bit0 is cleared.
  - ICsrr: link=1, pclink=sepc, RegWrite=1; clears in_isr.
  - UType: IMM=IR[31:12]<<12 truncated; ALUSrc=1; RS1=0; RegWrite=1.
- MEM:
  - MemRead (load) or MemWrite (store) held high while busy=1.
  - busy=0: load → WB; store → FETCH.
- WB (one cycle): MemtoReg=1, RegWrite=1, RD=IR[11:7]; then FETCH.
- Instruction completion (last state of an instruction):
  - If interrupt && !in_isr: sepc<=next pc; pc<=IVEC; in_isr<=1.
  - Else pc<=next pc.
  - Interrupts are never taken mid-instruction or mid-MEM.
- RD=0 writes are suppressed: RegWrite=0.
- PC arithmetic is modulo 2^NBITS; wrap is silent.
- Reset during MEM or FETCH aborts immediately; MemRead and MemWrite drop in the same cycle reset is sampled.

Optional Feature:
- Macro: CTRL_ILLEGAL_TRAP_EN.
- Defined: an undecoded opcode in EXEC pulses illegal for 1 cycle, sets sepc=pc, pc=IVEC, in_isr=1, and suppresses RegWrite. This happens regardless of in_isr.
- Undefined: an undecoded opcode executes as a NOP (pc+4); illegal is tied 0.

Test Plan:
- Reset, then ADDI x5,x0,3 (0x00300293), instr_valid 1 cycle after request → EXEC cycle shows ALUSrc=1, RD=5, IMM=3, RegWrite=1; instr_addr becomes 4.
- SLL x3,x1,x2 (0x002091B3) → ALUControl=0001, ALUSrc=0, RS1=1, RS2=2, RD=3.
- LW x4,8(x1) with busy high 3 cycles → MemRead high for 4 cycles, then one WB cycle with MemtoReg=1; next fetch at pc+4.
- BEQ at pc=8, IMM=−8, Zero=1 → next instr_addr=0; same instruction with Zero=0 → 12.
- interrupt asserted during LW's MEM state → load completes, sepc=pc+4, instr_addr=IVEC; a second interrupt is ignored until CSRR executes, and CSRR writes pclink=sepc.
- Reset asserted mid-MEM with busy=1 → MemRead=0 on the next cycle, state=FETCH, instr_addr=0.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle RV32I-subset control unit: FETCH -> EXEC -> (MEM -> WB), interrupts taken at instruction boundaries.
// Define CTRL_ILLEGAL_TRAP_EN to trap undecoded opcodes to IVEC; ALUResult returns the ULA sum used as the JALR target.
module multicycle_controller #(
  parameter int               NBITS       = 8,
  parameter int               NREGS       = 32,
  parameter int               WIDTH_ALUF  = 4,
  parameter int               NINSTR_BITS = 32,
  parameter logic [NBITS-1:0] IVEC        = NBITS'(8'h10)
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic                     instr_req,
  output logic [NBITS-1:0]         instr_addr,
  input  logic                     instr_valid,
  input  logic [NINSTR_BITS-1:0]   instr,
  output logic [$clog2(NREGS)-1:0] RS1,
  output logic [$clog2(NREGS)-1:0] RS2,
  output logic [$clog2(NREGS)-1:0] RD,
  output logic [NBITS-1:0]         IMM,
  output logic                     ALUSrc,
  output logic [WIDTH_ALUF-1:0]    ALUControl,
  output logic                     MemtoReg,
  output logic                     RegWrite,
  output logic                     link,
  output logic [NBITS-1:0]         pclink,
  input  logic                     Zero,
  input  logic                     Neg,
  input  logic                     Carry,
  input  logic [NBITS-1:0]         ALUResult,
  output logic                     MemRead,
  output logic                     MemWrite,
  input  logic                     busy,
  input  logic                     interrupt,
  output logic                     illegal,
  output logic [NBITS-1:0]         dbg_pc,
  output logic [1:0]               dbg_state
);

  localparam int RBITS = $clog2(NREGS);

  typedef enum logic [1:0] {FETCH = 2'd0, EXEC = 2'd1, MEM = 2'd2, WB = 2'd3} state_t;

  typedef enum logic [4:0] {
    OP_LOAD   = 5'b00000,
    OP_IMM    = 5'b00100,
    OP_STORE  = 5'b01000,
    OP_REG    = 5'b01100,
    OP_LUI    = 5'b01101,
    OP_BRANCH = 5'b11000,
    OP_JALR   = 5'b11001,
    OP_JAL    = 5'b11011,
    OP_SYSTEM = 5'b11100
  } opcode_t;

  localparam logic [WIDTH_ALUF-1:0] ALU_ADD = WIDTH_ALUF'(4'b0000);
  localparam logic [WIDTH_ALUF-1:0] ALU_SUB = WIDTH_ALUF'(4'b1000);

  state_t                 state, state_next;
  logic [NINSTR_BITS-1:0] ir;
  logic [NBITS-1:0]       pc, sepc, pc_next, pc_plus4;
  logic                   in_isr, complete, trap, clear_isr, branch_taken, is_load;
  opcode_t                opc;
  logic [2:0]             funct3;
  logic                   funct7_5;
  logic [RBITS-1:0]       ir_rs1, ir_rs2, ir_rd;
  logic [NBITS-1:0]       imm_i, imm_s, imm_b, imm_j, imm_u;
  logic [WIDTH_ALUF-1:0]  alu_reg, alu_imm;
  logic                   unused_ir;

  // Immediates are built at 32 bits, then sign-extended or truncated to the datapath width.
  function automatic logic [NBITS-1:0] sext(input logic [31:0] v);
    return NBITS'($signed(v));
  endfunction

  assign opc       = opcode_t'(ir[6:2]);
  assign funct3    = ir[14:12];
  assign funct7_5  = ir[30];
  assign ir_rs1    = RBITS'(ir[19:15]);
  assign ir_rs2    = RBITS'(ir[24:20]);
  assign ir_rd     = RBITS'(ir[11:7]);
  assign unused_ir = ^ir[1:0];

  assign imm_i = sext({{20{ir[31]}}, ir[31:20]});
  assign imm_s = sext({{20{ir[31]}}, ir[31:25], ir[11:7]});
  assign imm_b = sext({{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0});
  assign imm_j = sext({{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0});
  assign imm_u = sext({ir[31:12], 12'b0});

  assign pc_plus4 = pc + NBITS'(4);
  assign is_load  = (opc == OP_LOAD);
  assign alu_reg  = WIDTH_ALUF'({funct7_5, funct3});
  // Only SRAI borrows funct7[5]; other I-type immediates may have bit 30 set.
  assign alu_imm  = (funct3 == 3'b101) ? WIDTH_ALUF'({funct7_5, funct3})
                                       : WIDTH_ALUF'({1'b0, funct3});

  always_comb begin
    case (funct3)
      3'b000:  branch_taken = Zero;
      3'b001:  branch_taken = !Zero;
      3'b100:  branch_taken = Neg;
      3'b101:  branch_taken = !Neg;
      3'b110:  branch_taken = !Carry;
      3'b111:  branch_taken = Carry;
      default: branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    // NOTE: every signal written here gets a default first so no path infers a latch.
    state_next = state;
    pc_next    = pc_plus4;
    complete   = 1'b0;
    trap       = 1'b0;
    clear_isr  = 1'b0;
    instr_req  = 1'b0;
    RS1        = '0;
    RS2        = '0;
    RD         = '0;
    IMM        = '0;
    ALUSrc     = 1'b0;
    ALUControl = ALU_ADD;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    link       = 1'b0;
    pclink     = '0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    illegal    = 1'b0;
    instr_addr = pc;
    dbg_pc     = pc;
    dbg_state  = state;

    unique case (state)
      FETCH: begin
        instr_req = 1'b1;
        if (instr_valid) state_next = EXEC;
      end

      EXEC: begin
        complete = 1'b1;
        case (opc)
          OP_REG: begin
            RS1 = ir_rs1; RS2 = ir_rs2; RD = ir_rd;
            ALUControl = alu_reg; RegWrite = 1'b1;
          end
          OP_IMM: begin
            RS1 = ir_rs1; RD = ir_rd; IMM = imm_i;
            ALUSrc = 1'b1; ALUControl = alu_imm; RegWrite = 1'b1;
          end
          OP_LOAD: begin
            RS1 = ir_rs1; RD = ir_rd; IMM = imm_i; ALUSrc = 1'b1;
            complete = 1'b0; state_next = MEM;
          end
          OP_STORE: begin
            RS1 = ir_rs1; RS2 = ir_rs2; IMM = imm_s; ALUSrc = 1'b1;
            complete = 1'b0; state_next = MEM;
          end
          OP_BRANCH: begin
            RS1 = ir_rs1; RS2 = ir_rs2; IMM = imm_b; ALUControl = ALU_SUB;
            if (branch_taken) pc_next = pc + imm_b;
          end
          OP_JAL: begin
            RD = ir_rd; IMM = imm_j; link = 1'b1; pclink = pc_plus4; RegWrite = 1'b1;
            pc_next = pc + imm_j;
          end
          OP_JALR: begin
            RS1 = ir_rs1; RD = ir_rd; IMM = imm_i; ALUSrc = 1'b1;
            link = 1'b1; pclink = pc_plus4; RegWrite = 1'b1;
            pc_next = ALUResult & ~NBITS'(1);
          end
          OP_SYSTEM: begin
            RD = ir_rd; link = 1'b1; pclink = sepc; RegWrite = 1'b1; clear_isr = 1'b1;
          end
          OP_LUI: begin
            RD = ir_rd; IMM = imm_u; ALUSrc = 1'b1; RegWrite = 1'b1;
          end
          default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            illegal = 1'b1;
            trap    = 1'b1;
`else
            trap    = 1'b0;
`endif
          end
        endcase
        if (complete) state_next = FETCH;
      end

      MEM: begin
        // Address operands stay on the bus until the memory accepts the access.
        RS1 = ir_rs1; ALUSrc = 1'b1;
        if (is_load) begin
          RD = ir_rd; IMM = imm_i; MemRead = 1'b1;
        end else begin
          RS2 = ir_rs2; IMM = imm_s; MemWrite = 1'b1;
        end
        if (!busy) begin
          if (is_load) state_next = WB;
          else begin
            state_next = FETCH;
            complete   = 1'b1;
          end
        end
      end

      WB: begin
        RD = ir_rd; MemtoReg = 1'b1; RegWrite = 1'b1;
        complete = 1'b1; state_next = FETCH;
      end
    endcase

    if (RD == '0) RegWrite = 1'b0;

    // Reset silences every output in the cycle it is sampled, aborting any memory access.
    if (reset) begin
      instr_req = 1'b0; instr_addr = '0; RS1 = '0; RS2 = '0; RD = '0; IMM = '0;
      ALUSrc = 1'b0; ALUControl = '0; MemtoReg = 1'b0; RegWrite = 1'b0; link = 1'b0;
      pclink = '0; MemRead = 1'b0; MemWrite = 1'b0; illegal = 1'b0;
      dbg_pc = '0; dbg_state = FETCH;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= FETCH;
      pc     <= '0;
      sepc   <= '0;
      in_isr <= 1'b0;
      ir     <= '0;
    end else begin
      state <= state_next;
      if (state == FETCH && instr_valid) ir <= instr;
      if (complete) begin
        if (trap) begin
          sepc   <= pc;
          pc     <= IVEC;
          in_isr <= 1'b1;
        end else if (interrupt && !in_isr) begin
          sepc   <= pc_next;
          pc     <= IVEC;
          in_isr <= 1'b1;
        end else begin
          pc <= pc_next;
          if (clear_isr) in_isr <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: a decode vector table plus hand-written multi-cycle sequences.
module tb_multicycle_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        instr_req, instr_valid;
  logic [7:0]  instr_addr;
  logic [31:0] instr;
  logic [4:0]  RS1, RS2, RD;
  logic [7:0]  IMM, pclink, ALUResult, dbg_pc;
  logic        ALUSrc, MemtoReg, RegWrite, link, Zero, Neg, Carry;
  logic [3:0]  ALUControl;
  logic        MemRead, MemWrite, busy, interrupt, illegal;
  logic [1:0]  dbg_state;

  always #5 clock = ~clock;

  multicycle_controller #(
    .NBITS(8), .NREGS(32), .WIDTH_ALUF(4), .NINSTR_BITS(32), .IVEC(8'h10)
  ) dut (
    .clock(clock), .reset(reset), .instr_req(instr_req), .instr_addr(instr_addr),
    .instr_valid(instr_valid), .instr(instr), .RS1(RS1), .RS2(RS2), .RD(RD), .IMM(IMM),
    .ALUSrc(ALUSrc), .ALUControl(ALUControl), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .link(link), .pclink(pclink), .Zero(Zero), .Neg(Neg), .Carry(Carry),
    .ALUResult(ALUResult), .MemRead(MemRead), .MemWrite(MemWrite), .busy(busy),
    .interrupt(interrupt), .illegal(illegal), .dbg_pc(dbg_pc), .dbg_state(dbg_state)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        zero, neg, carry;
    logic [7:0]  alu_res;
    logic [4:0]  rs1, rs2, rd;
    logic [7:0]  imm;
    logic        alusrc;
    logic [3:0]  aluc;
    logic        regwrite, lnk;
    logic [7:0]  pcl;
    logic        ill;
    logic [7:0]  next_pc;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; instr_valid = 1'b0; busy = 1'b0; interrupt = 1'b0;
    Zero = 1'b0; Neg = 1'b0; Carry = 1'b0; ALUResult = 8'h00;
    tick(); tick();
    reset = 1'b0;
    #1;
  endtask

  // Presents one instruction for a single cycle; afterwards the DUT sits in EXEC.
  task automatic fetch(input logic [31:0] w);
    instr = w; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0; instr = 32'hFFFF_FFFF;
    #1;
  endtask

  task automatic run_instr(input logic [31:0] w);
    fetch(w);
    tick();
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction

  function automatic logic [63:0] pack_dec(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                           input logic [7:0] imm, input logic alusrc, input logic [3:0] aluc,
                                           input logic rw, input logic lk, input logic [7:0] pcl, input logic ill);
    return 64'({rs1, rs2, rd, imm, alusrc, aluc, rw, lk, pcl, ill});
  endfunction

  task automatic add(input string name, input logic [31:0] w, input logic z, input logic n, input logic c,
                     input logic [7:0] ar, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                     input logic [7:0] imm, input logic src, input logic [3:0] aluc, input logic rw,
                     input logic lk, input logic [7:0] pcl, input logic ill, input logic [7:0] nxt);
    vec_t v;
    v.name = name; v.instr = w; v.zero = z; v.neg = n; v.carry = c; v.alu_res = ar;
    v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.imm = imm; v.alusrc = src; v.aluc = aluc;
    v.regwrite = rw; v.lnk = lk; v.pcl = pcl; v.ill = ill; v.next_pc = nxt;
    vecs.push_back(v);
  endtask

  localparam logic [31:0] CSRR_X3 = 32'h141021F3;
  localparam logic [31:0] ADDI_NOP = 32'h00000013;
  logic [31:0] lw_x4;
  logic [31:0] sw_x2;

  initial begin
    instr = '0; instr_valid = 1'b0; busy = 1'b0; interrupt = 1'b0;
    Zero = 1'b0; Neg = 1'b0; Carry = 1'b0; ALUResult = 8'h00;
    lw_x4 = enc_i(12'h008, 5'd1, 3'd2, 5'd4, 7'h03);
    sw_x2 = enc_s(12'h00C, 5'd2, 5'd1, 3'd2);

    // name, instr, Z, N, C, ALUResult | RS1, RS2, RD, IMM, ALUSrc, ALUControl, RegWrite, link, pclink, illegal, next pc
    add("addi",    32'h00300293,                              1'b0,1'b0,1'b0, 8'h00, 5'd0, 5'd0, 5'd5, 8'h03, 1'b1, 4'h0, 1'b1,1'b0, 8'h00, 1'b0, 8'h04);
    add("sll",     32'h002091B3,                              1'b0,1'b0,1'b0, 8'h00, 5'd1, 5'd2, 5'd3, 8'h00, 1'b0, 4'h1, 1'b1,1'b0, 8'h00, 1'b0, 8'h04);
    add("sub",     enc_r(7'h20, 5'd8, 5'd7, 3'd0, 5'd6),      1'b0,1'b0,1'b0, 8'h00, 5'd7, 5'd8, 5'd6, 8'h00, 1'b0, 4'h8, 1'b1,1'b0, 8'h00, 1'b0, 8'h04);
    add("srai",    enc_i(12'h402, 5'd10, 3'd5, 5'd9, 7'h13),  1'b0,1'b0,1'b0, 8'h00, 5'd10,5'd0, 5'd9, 8'h02, 1'b1, 4'hD, 1'b1,1'b0, 8'h00, 1'b0, 8'h04);
    add("srli",    enc_i(12'h002, 5'd10, 3'd5, 5'd9, 7'h13),  1'b0,1'b0,1'b0, 8'h00, 5'd10,5'd0, 5'd9, 8'h02, 1'b1, 4'h5, 1'b1,1'b0, 8'h00, 1'b0, 8'h04);
    add("ori_b30", enc_i(12'h400, 5'd2, 3'd6, 5'd1, 7'h13),   1'b0,1'b0,1'b0, 8'h00, 5'd2, 5'd0, 5'd1, 8'h00, 1'b1, 4'h6, 1'b1,1'b0, 8'h00, 1'b0, 8'h04);
    add("xori_m1", enc_i(12'hFFF, 5'd2, 3'd4, 5'd1, 7'h13),   1'b0,1'b0,1'b0, 8'h00, 5'd2, 5'd0, 5'd1, 8'hFF, 1'b1, 4'h4, 1'b1,1'b0, 8'h00, 1'b0, 8'h04);
    add("addi_x0", enc_i(12'h005, 5'd1, 3'd0, 5'd0, 7'h13),   1'b0,1'b0,1'b0, 8'h00, 5'd1, 5'd0, 5'd0, 8'h05, 1'b1, 4'h0, 1'b0,1'b0, 8'h00, 1'b0, 8'h04);
    add("lui",     32'h123453B7,                              1'b0,1'b0,1'b0, 8'h00, 5'd0, 5'd0, 5'd7, 8'h00, 1'b1, 4'h0, 1'b1,1'b0, 8'h00, 1'b0, 8'h04);
    add("jal_fwd", enc_j(21'h000014, 5'd1),                   1'b0,1'b0,1'b0, 8'h00, 5'd0, 5'd0, 5'd1, 8'h14, 1'b0, 4'h0, 1'b1,1'b1, 8'h04, 1'b0, 8'h14);
    add("jal_wrap",enc_j(21'h1FFFFC, 5'd1),                   1'b0,1'b0,1'b0, 8'h00, 5'd0, 5'd0, 5'd1, 8'hFC, 1'b0, 4'h0, 1'b1,1'b1, 8'h04, 1'b0, 8'hFC);
    add("jalr",    enc_i(12'h005, 5'd2, 3'd0, 5'd1, 7'h67),   1'b0,1'b0,1'b0, 8'h25, 5'd2, 5'd0, 5'd1, 8'h05, 1'b1, 4'h0, 1'b1,1'b1, 8'h04, 1'b0, 8'h24);
    add("csrr",    CSRR_X3,                                   1'b0,1'b0,1'b0, 8'h00, 5'd0, 5'd0, 5'd3, 8'h00, 1'b0, 4'h0, 1'b1,1'b1, 8'h00, 1'b0, 8'h04);
    add("beq_t",   enc_b(13'h0010, 5'd2, 5'd1, 3'd0),         1'b1,1'b0,1'b0, 8'h00, 5'd1, 5'd2, 5'd0, 8'h10, 1'b0, 4'h8, 1'b0,1'b0, 8'h00, 1'b0, 8'h10);
    add("bne_nt",  enc_b(13'h0010, 5'd2, 5'd1, 3'd1),         1'b1,1'b0,1'b0, 8'h00, 5'd1, 5'd2, 5'd0, 8'h10, 1'b0, 4'h8, 1'b0,1'b0, 8'h00, 1'b0, 8'h04);
    add("blt_t",   enc_b(13'h0010, 5'd2, 5'd1, 3'd4),         1'b0,1'b1,1'b0, 8'h00, 5'd1, 5'd2, 5'd0, 8'h10, 1'b0, 4'h8, 1'b0,1'b0, 8'h00, 1'b0, 8'h10);
    add("bge_nt",  enc_b(13'h0010, 5'd2, 5'd1, 3'd5),         1'b0,1'b1,1'b0, 8'h00, 5'd1, 5'd2, 5'd0, 8'h10, 1'b0, 4'h8, 1'b0,1'b0, 8'h00, 1'b0, 8'h04);
    add("bltu_t",  enc_b(13'h0010, 5'd2, 5'd1, 3'd6),         1'b0,1'b0,1'b0, 8'h00, 5'd1, 5'd2, 5'd0, 8'h10, 1'b0, 4'h8, 1'b0,1'b0, 8'h00, 1'b0, 8'h10);
    add("bgeu_nt", enc_b(13'h0010, 5'd2, 5'd1, 3'd7),         1'b0,1'b0,1'b0, 8'h00, 5'd1, 5'd2, 5'd0, 8'h10, 1'b0, 4'h8, 1'b0,1'b0, 8'h00, 1'b0, 8'h04);
    add("bgeu_t",  enc_b(13'h0010, 5'd2, 5'd1, 3'd7),         1'b0,1'b0,1'b1, 8'h00, 5'd1, 5'd2, 5'd0, 8'h10, 1'b0, 4'h8, 1'b0,1'b0, 8'h00, 1'b0, 8'h10);
`ifdef CTRL_ILLEGAL_TRAP_EN
    add("undecoded", 32'h0000007F,                            1'b0,1'b0,1'b0, 8'h00, 5'd0, 5'd0, 5'd0, 8'h00, 1'b0, 4'h0, 1'b0,1'b0, 8'h00, 1'b1, 8'h10);
`else
    add("undecoded", 32'h0000007F,                            1'b0,1'b0,1'b0, 8'h00, 5'd0, 5'd0, 5'd0, 8'h00, 1'b0, 4'h0, 1'b0,1'b0, 8'h00, 1'b0, 8'h04);
`endif

    // Reset values, both while reset is held and right after release.
    tick();
    check("rst_req_held",   64'(instr_req), 64'd0);
    check("rst_addr_held",  64'(instr_addr), 64'd0);
    check("rst_state_held", 64'(dbg_state), 64'd0);
    do_reset();
    check("rst_req",  64'(instr_req), 64'd1);
    check("rst_addr", 64'(instr_addr), 64'd0);
    check("rst_dbgpc", 64'(dbg_pc), 64'd0);

    // Request held with no valid instruction: must stay in FETCH.
    tick();
    check("fetch_wait_state", 64'(dbg_state), 64'd0);
    check("fetch_wait_req",   64'(instr_req), 64'd1);

    foreach (vecs[i]) begin
      do_reset();
      fetch(vecs[i].instr);
      Zero = vecs[i].zero; Neg = vecs[i].neg; Carry = vecs[i].carry; ALUResult = vecs[i].alu_res;
      #1;
      check({vecs[i].name, "_state"}, 64'(dbg_state), 64'd1);
      check({vecs[i].name, "_decode"},
            pack_dec(RS1, RS2, RD, IMM, ALUSrc, ALUControl, RegWrite, link, pclink, illegal),
            pack_dec(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].imm, vecs[i].alusrc, vecs[i].aluc,
                     vecs[i].regwrite, vecs[i].lnk, vecs[i].pcl, vecs[i].ill));
      tick();
      check({vecs[i].name, "_next_pc"}, 64'(instr_addr), 64'(vecs[i].next_pc));
      check({vecs[i].name, "_illegal_clr"}, 64'(illegal), 64'd0);
    end

    // LW with busy high for three MEM cycles: four MemRead cycles, one WB, next fetch at 4.
    do_reset();
    fetch(lw_x4);
    check("lw_exec_memread", 64'(MemRead), 64'd0);
    busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("lw_mem_busy_read", 64'(MemRead), 64'd1);
    end
    check("lw_mem_state", 64'(dbg_state), 64'd2);
    busy = 1'b0;
    #1;
    check("lw_mem_last_read", 64'(MemRead), 64'd1);
    tick();
    check("lw_wb", 64'({dbg_state, MemtoReg, RegWrite, RD, MemRead}), 64'({2'd3, 1'b1, 1'b1, 5'd4, 1'b0}));
    tick();
    check("lw_next_addr", 64'(instr_addr), 64'd4);
    check("lw_next_state", 64'(dbg_state), 64'd0);

    // SW with memory ready: one MEM cycle, no WB.
    do_reset();
    fetch(sw_x2);
    check("sw_exec", pack_dec(RS1, RS2, RD, IMM, ALUSrc, ALUControl, RegWrite, link, pclink, illegal),
          pack_dec(5'd1, 5'd2, 5'd0, 8'h0C, 1'b1, 4'h0, 1'b0, 1'b0, 8'h00, 1'b0));
    tick();
    check("sw_memwrite", 64'({dbg_state, MemWrite, MemRead}), 64'({2'd2, 1'b1, 1'b0}));
    tick();
    check("sw_next", 64'({dbg_state, instr_addr, MemWrite}), 64'({2'd0, 8'h04, 1'b0}));

    // BEQ at pc=8 with offset -8, taken then not taken.
    do_reset();
    run_instr(ADDI_NOP); run_instr(ADDI_NOP);
    check("beq_pc8", 64'(instr_addr), 64'd8);
    fetch(enc_b(13'h1FF8, 5'd2, 5'd1, 3'd0));
    Zero = 1'b1;
    #1;
    check("beq_imm_neg", 64'(IMM), 64'hF8);
    tick();
    check("beq_taken_addr", 64'(instr_addr), 64'd0);
    do_reset();
    run_instr(ADDI_NOP); run_instr(ADDI_NOP);
    fetch(enc_b(13'h1FF8, 5'd2, 5'd1, 3'd0));
    Zero = 1'b0;
    tick();
    check("beq_not_taken_addr", 64'(instr_addr), 64'd12);

    // Interrupt raised during LW's MEM: taken only once the load retires.
    do_reset();
    fetch(lw_x4);
    busy = 1'b1;
    tick();
    interrupt = 1'b1;
    #1;
    check("irq_mem_state", 64'(dbg_state), 64'd2);
    tick();
    busy = 1'b0;
    #1;
    check("irq_not_mid_mem", 64'({dbg_state, instr_addr}), 64'({2'd2, 8'h00}));
    tick();
    check("irq_not_at_wb", 64'({dbg_state, instr_addr}), 64'({2'd3, 8'h00}));
    tick();
    check("irq_vector", 64'(instr_addr), 64'h10);
    run_instr(ADDI_NOP);
    check("irq_nested_ignored", 64'(instr_addr), 64'h14);
    fetch(CSRR_X3);
    check("csrr_sepc", 64'({link, pclink, RD, RegWrite}), 64'({1'b1, 8'h04, 5'd3, 1'b1}));
    tick();
    check("csrr_next", 64'(instr_addr), 64'h18);
    run_instr(ADDI_NOP);
    check("irq_retaken", 64'(instr_addr), 64'h10);
    interrupt = 1'b0;
    fetch(CSRR_X3);
    check("csrr_sepc2", 64'(pclink), 64'h1C);
    tick();
    check("csrr_next2", 64'(instr_addr), 64'h14);

    // Reset mid-MEM with busy high aborts the read in the same cycle.
    do_reset();
    fetch(lw_x4);
    busy = 1'b1;
    tick();
    check("rstmem_read_before", 64'(MemRead), 64'd1);
    reset = 1'b1;
    #1;
    check("rstmem_read_same_cycle", 64'(MemRead), 64'd0);
    tick();
    check("rstmem_after", 64'({dbg_state, instr_addr, MemRead}), 64'({2'd0, 8'h00, 1'b0}));
    reset = 1'b0; busy = 1'b0;
    #1;
    check("rstmem_refetch", 64'(instr_req), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
